// File: rtl/hrglass_timer_if.sv
// Strategy-driver <-> hourglass timer bus.
// master : turn-strategy driver (start/target/tick/turns out, status in)
// slave  : hrglass_timer (status out)
// The "hourglass ran out" strobe is carried as evAny because "event" is a
// reserved word in SystemVerilog.
interface hrglass_timer_if #(
   parameter int unsigned W  = 8,
   parameter int unsigned CW = 3
);
   logic          start;
   logic [W-1:0]  target;
   logic          tick;
   logic          turnSmall;
   logic          turnLarge;
   logic          evAny;
   logic          evSmall;
   logic          evLarge;
   logic [W-1:0]  elapsed;
   logic [CW-1:0] smallTop;
   logic [CW-1:0] largeTop;
   logic          busy;
   logic          done;
   logic          failed;

   modport master (
      output start, target, tick, turnSmall, turnLarge,
      input  evAny, evSmall, evLarge, elapsed, smallTop, largeTop, busy, done, failed
   );

   modport slave (
      input  start, target, tick, turnSmall, turnLarge,
      output evAny, evSmall, evLarge, elapsed, smallTop, largeTop, busy, done, failed
   );
endinterface

// File: rtl/hrglass_timer.sv
// Two-hourglass (SMALL / LARGE minute) puzzle environment, one minute per tick.
// Emits registered "ran out" events and reports whether target was hit
// exactly on an event boundary (DONE) or missed / stalled (FAIL).
// Ports:
//   clock   : sole clock, posedge
//   reset_n : asynchronous active-low reset
//   bus     : hrglass_timer_if.slave (start/target/tick/turns in;
//             evAny/evSmall/evLarge/elapsed/tops/busy/done/failed out)
// Optional: define HRGLASS_STRICT_TURN_EN to fail on turns issued in RUN
// outside an event cycle (otherwise they are ignored).
module hrglass_timer #(
   parameter int unsigned W     = 8,
   parameter int unsigned SMALL = 4,
   parameter int unsigned LARGE = 7,
   parameter int unsigned CW    = 3
) (
   input  logic          clock,
   input  logic          reset_n,
   hrglass_timer_if.slave bus
);

   localparam logic [CW-1:0] CAP_S       = CW'(SMALL);
   localparam logic [CW-1:0] CAP_L       = CW'(LARGE);
   localparam logic [W-1:0]  ELAPSED_MAX = '1;

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE, S_FAIL} state_e;

   state_e        state_q,    state_d;
   logic [W-1:0]  target_q,   target_d;
   logic [W-1:0]  elapsed_q,  elapsed_d;
   logic [CW-1:0] small_q,    small_d;
   logic [CW-1:0] large_q,    large_d;
   logic          ev_small_q, ev_small_d;
   logic          ev_large_q, ev_large_d;
   logic          event_q;
   logic          busy_q, done_q, failed_q;

   // post-flip tops, used as the base for a same-cycle decrement
   logic [CW-1:0] small_f, large_f;
   logic          tick_en;

   // next-state logic
   always_comb begin
      state_d    = state_q;
      target_d   = target_q;
      elapsed_d  = elapsed_q;
      small_d    = small_q;
      large_d    = large_q;
      ev_small_d = 1'b0;
      ev_large_d = 1'b0;
      small_f    = small_q;
      large_f    = large_q;
      tick_en    = 1'b0;

      unique case (state_q)
         S_IDLE: begin
            if (bus.start) begin
               target_d  = bus.target;
               elapsed_d = '0;
               small_f   = bus.turnSmall ? CAP_S - small_q : small_q;
               large_f   = bus.turnLarge ? CAP_L - large_q : large_q;
               small_d   = small_f;
               large_d   = large_f;
               if (bus.target == '0)                      state_d = S_DONE;
               else if (small_f == '0 && large_f == '0)   state_d = S_FAIL;
               else                                       state_d = S_RUN;
            end
         end
         S_RUN: begin
            if (event_q && elapsed_q == target_q) begin
               // exact hit on an event boundary; turns and tick are moot
               state_d = S_DONE;
            end else if (event_q) begin
               small_f = bus.turnSmall ? CAP_S - small_q : small_q;
               large_f = bus.turnLarge ? CAP_L - large_q : large_q;
               small_d = small_f;
               large_d = large_f;
               if (small_f == '0 && large_f == '0) state_d = S_FAIL;
               else                                tick_en = bus.tick;
            end
`ifdef HRGLASS_STRICT_TURN_EN
            else if (bus.turnSmall || bus.turnLarge) begin
               state_d = S_FAIL;
            end
`endif
            else begin
               tick_en = bus.tick;
            end

            if (tick_en) begin
               if (elapsed_q == ELAPSED_MAX) begin
                  state_d = S_FAIL;
               end else begin
                  elapsed_d = elapsed_q + W'(1);
                  small_d   = small_f - CW'(small_f != '0);
                  large_d   = large_f - CW'(large_f != '0);
                  if (elapsed_d > target_q) begin
                     state_d = S_FAIL;
                  end else begin
                     ev_small_d = (small_f == CW'(1));
                     ev_large_d = (large_f == CW'(1));
                  end
               end
            end
         end
         default: ;
      endcase
   end

   // state and output registers
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= S_IDLE;
         target_q   <= '0;
         elapsed_q  <= '0;
         small_q    <= '0;
         large_q    <= '0;
         ev_small_q <= 1'b0;
         ev_large_q <= 1'b0;
         event_q    <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         failed_q   <= 1'b0;
      end else begin
         state_q    <= state_d;
         target_q   <= target_d;
         elapsed_q  <= elapsed_d;
         small_q    <= small_d;
         large_q    <= large_d;
         ev_small_q <= ev_small_d;
         ev_large_q <= ev_large_d;
         event_q    <= ev_small_d | ev_large_d;
         busy_q     <= (state_d == S_RUN);
         done_q     <= (state_d == S_DONE);
         failed_q   <= (state_d == S_FAIL);
      end
   end

   assign bus.evAny    = event_q;
   assign bus.evSmall  = ev_small_q;
   assign bus.evLarge  = ev_large_q;
   assign bus.elapsed  = elapsed_q;
   assign bus.smallTop = small_q;
   assign bus.largeTop = large_q;
   assign bus.busy     = busy_q;
   assign bus.done     = done_q;
   assign bus.failed   = failed_q;

endmodule

// File: tb/tb_hrglass_timer.sv
// Directed bench for hrglass_timer: puzzle scenarios with hand-computed results.
module tb_hrglass_timer;

   logic clk;
   logic rst_n;
   int   n_checks;
   int   n_errors;

   hrglass_timer_if #(.W(8), .CW(3)) bus ();

   hrglass_timer #(.W(8), .SMALL(4), .LARGE(7), .CW(3)) dut (
      .clock   (clk),
      .reset_n (rst_n),
      .bus     (bus)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string tag, input int unsigned got, input int unsigned exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // advance one clock; outputs are sampled 1ns after the edge
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      #3;
      rst_n = 1'b1;
      step();
   endtask

   task automatic do_start(input int unsigned tgt, input bit ts, input bit tl);
      bus.start     = 1'b1;
      bus.target    = 8'(tgt);
      bus.turnSmall = ts;
      bus.turnLarge = tl;
      step();
      bus.start     = 1'b0;
      bus.turnSmall = 1'b0;
      bus.turnLarge = 1'b0;
   endtask

   // back-to-back one-cycle tick pulses
   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) begin
         bus.tick = 1'b1;
         step();
      end
      bus.tick = 1'b0;
   endtask

   // one cycle with optional turns (used on event cycles)
   task automatic turn_cycle(input bit ts, input bit tl);
      bus.turnSmall = ts;
      bus.turnLarge = tl;
      step();
      bus.turnSmall = 1'b0;
      bus.turnLarge = 1'b0;
   endtask

   initial begin
      n_checks      = 0;
      n_errors      = 0;
      rst_n         = 1'b0;
      bus.start     = 1'b0;
      bus.target    = '0;
      bus.tick      = 1'b0;
      bus.turnSmall = 1'b0;
      bus.turnLarge = 1'b0;
      #12;
      chk("rst_elapsed", bus.elapsed, 0);
      chk("rst_small",   bus.smallTop, 0);
      chk("rst_large",   bus.largeTop, 0);
      chk("rst_busy",    bus.busy, 0);
      chk("rst_done",    bus.done, 0);
      chk("rst_failed",  bus.failed, 0);
      chk("rst_event",   bus.evAny, 0);
      rst_n = 1'b1;
      step();

      // target 4, small only
      do_start(4, 1, 0);
      chk("t4_busy",  bus.busy, 1);
      chk("t4_small", bus.smallTop, 4);
      ticks(4);
      chk("t4_event",   bus.evAny, 1);
      chk("t4_evsmall", bus.evSmall, 1);
      chk("t4_evlarge", bus.evLarge, 0);
      chk("t4_elapsed", bus.elapsed, 4);
      step();
      chk("t4_done",    bus.done, 1);
      chk("t4_failed",  bus.failed, 0);
      chk("t4_evclr",   bus.evAny, 0);
      // DONE is sticky: start and tick ignored
      do_start(5, 1, 1);
      ticks(1);
      chk("t4_hold_el",   bus.elapsed, 4);
      chk("t4_hold_sm",   bus.smallTop, 0);
      chk("t4_hold_done", bus.done, 1);

      // target 8, small re-turned at 4
      do_reset();
      do_start(8, 1, 0);
      ticks(4);
      chk("t8_event4", bus.evAny, 1);
      turn_cycle(1, 0);
      chk("t8_small4", bus.smallTop, 4);
      ticks(4);
      chk("t8_event8", bus.evAny, 1);
      step();
      chk("t8_done",    bus.done, 1);
      chk("t8_elapsed", bus.elapsed, 8);
      chk("t8_small",   bus.smallTop, 0);

      // target 10, classic solution
      do_reset();
      do_start(10, 1, 1);
      chk("t10_small0", bus.smallTop, 4);
      chk("t10_large0", bus.largeTop, 7);
      ticks(4);
      chk("t10_evs4", bus.evSmall, 1);
      chk("t10_evl4", bus.evLarge, 0);
      turn_cycle(1, 0);
      chk("t10_small4", bus.smallTop, 4);
      chk("t10_large4", bus.largeTop, 3);
      ticks(3);
      chk("t10_evl7", bus.evLarge, 1);
      chk("t10_evs7", bus.evSmall, 0);
      chk("t10_sm7",  bus.smallTop, 1);
      turn_cycle(1, 0);
      chk("t10_small7", bus.smallTop, 3);
      ticks(3);
      chk("t10_evs10", bus.evSmall, 1);
      step();
      chk("t10_done",    bus.done, 1);
      chk("t10_elapsed", bus.elapsed, 10);

      // target 5 overshoot
      do_reset();
      do_start(5, 1, 1);
      ticks(4);
      chk("t5_event4", bus.evAny, 1);
      step();
      chk("t5_busy", bus.busy, 1);
      ticks(1);
      chk("t5_el5",   bus.elapsed, 5);
      chk("t5_noev5", bus.evAny, 0);
      ticks(1);
      chk("t5_failed", bus.failed, 1);
      chk("t5_done",   bus.done, 0);
      chk("t5_el6",    bus.elapsed, 6);

      // target 7 stall
      do_reset();
      do_start(7, 1, 0);
      ticks(4);
      step();
      chk("t7_failed",  bus.failed, 1);
      chk("t7_elapsed", bus.elapsed, 4);

      // nothing running at start
      do_reset();
      do_start(3, 0, 0);
      chk("t3_failed", bus.failed, 1);
      chk("t3_busy",   bus.busy, 0);

      // reset mid-run, then zero target
      do_reset();
      do_start(20, 1, 1);
      ticks(3);
      chk("rm_el3", bus.elapsed, 3);
      rst_n = 1'b0;
      #2;
      chk("rm_elapsed", bus.elapsed, 0);
      chk("rm_small",   bus.smallTop, 0);
      chk("rm_large",   bus.largeTop, 0);
      chk("rm_busy",    bus.busy, 0);
      rst_n = 1'b1;
      step();
      do_start(0, 0, 0);
      chk("t0_done", bus.done, 1);
      chk("t0_busy", bus.busy, 0);

      // turn outside an event cycle
      do_reset();
      do_start(9, 1, 1);
      ticks(2);
      chk("st_el2", bus.elapsed, 2);
      turn_cycle(0, 1);
`ifdef HRGLASS_STRICT_TURN_EN
      chk("st_failed", bus.failed, 1);
`else
      chk("st_failed", bus.failed, 0);
      chk("st_busy",   bus.busy, 1);
      chk("st_large",  bus.largeTop, 5);
`endif

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
